// File: rtl/uart_arb_pkg.sv
// Shared encodings for the UART TX arbiter: one-hot FSM states, LED bit map, default timeout.
package uart_arb_pkg;

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_START     = 5'b00010,
    S_WAIT_BUSY = 5'b00100,
    S_WAIT_DONE = 5'b01000
  } arb_state_t;

  localparam int STATE_LSB        = 0;
  localparam int ERR_BIT          = 5;
  localparam int REQ_LSB          = 6;
  localparam int LED_W            = 10;
  localparam int DEF_BUSY_TIMEOUT = 1023;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake plus UART TX side of the arbiter; master = arbiter, slave = sources/UART.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_start;
  logic                      tx_busy;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit strictly after ptr, wrapping; purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);

  int            idx_i;
  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx_i = 0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx_i = (int'(ptr) + k) % N;
      idx   = IW'(idx_i);
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX among NUM_REQ sources; accept at N, tx_start at N+1, >=4 cycles/byte.
// Optional packet lock under `UART_ARB_PKT_LOCK_EN: a source keeps the grant until its req_last byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_tx_arbiter_if.master          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [3:0]                 svn_seg_0_val,
  output logic [LED_W-1:0]           states_leds,
  output logic                       err_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t         state;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      ptr;
  logic               run_q;
  logic [NUM_REQ-1:0] elig;
  logic [IW-1:0]      pick;
  logic               pick_any;
  logic               accept;
  logic [LED_W-1:0]   leds_next;

`ifdef UART_ARB_PKT_LOCK_EN
  logic lock_q;

  // While locked only the last-granted source may win; ptr holds its index.
  always_comb begin
    elig = bus.req_valid;
    if (lock_q)
      elig = bus.req_valid & (NUM_REQ'(1) << ptr);
  end
`else
  logic unused_last;
  assign unused_last = ^bus.req_last;
  assign elig        = bus.req_valid;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (elig),
    .ptr   (ptr),
    .grant (pick),
    .any   (pick_any)
  );

  // run_q keeps req_ready low for the first cycle out of reset and while rst is held.
  assign accept = run_q && (state == S_IDLE) && pick_any && !bus.tx_busy;

  always_comb begin
    bus.req_ready = '0;
    if (accept)
      bus.req_ready[pick] = 1'b1;
  end

  always_comb begin
    leds_next                   = '0;
    leds_next[STATE_LSB +: 5]   = state;
    leds_next[ERR_BIT]          = err_timeout;
    leds_next[REQ_LSB +: 4]     = 4'(bus.req_valid);
  end

  assign svn_seg_0_val = 4'(grant_id);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ptr         <= IW'(NUM_REQ - 1);
      run_q       <= 1'b0;
      bus.tx_data <= '0;
      bus.tx_start <= 1'b0;
      grant_id    <= '0;
      err_timeout <= 1'b0;
      states_leds <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      run_q       <= 1'b1;
      states_leds <= leds_next;
      case (state)
        S_IDLE: begin
          if (accept) begin
            bus.tx_data  <= bus.req_data[pick*DATA_W +: DATA_W];
            grant_id     <= pick;
            ptr          <= pick;
            bus.tx_start <= 1'b1;
            state        <= S_START;
`ifdef UART_ARB_PKT_LOCK_EN
            lock_q       <= !bus.req_last[pick];
`endif
          end
        end
        S_START: begin
          bus.tx_start <= 1'b0;
          cnt          <= '0;
          state        <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (cnt == CW'(BUSY_TIMEOUT)) begin
            // UART never answered: drop the byte and flag it until reset.
            err_timeout <= 1'b1;
            state       <= S_IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
            lock_q      <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
